// File: rtl/lock_ctrl.sv
// lock_ctrl: serial code entry lock controller with fail counting, timed unlock and lockout windows
module lock_ctrl #(
    parameter int CODE_LEN = 5,
    parameter logic [CODE_LEN-1:0] RESET_CODE = 5'b01011,
    parameter int MAX_FAIL = 3,
    parameter int UNLOCK_CYC = 16,
    parameter int LOCKOUT_CYC = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                bit_valid,
    input  logic                                bit_in,
    input  logic                                cancel,
    input  logic                                relock,
    input  logic                                cfg_we,
    input  logic [CODE_LEN-1:0]                 cfg_code,
    output logic                                unlocked,
    output logic                                alarm,
    output logic                                fail_pulse,
    output logic [$clog2(MAX_FAIL+1)-1:0]       fail_cnt,
    output logic                                entry_busy
);
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int TMAX = UNLOCK_CYC > LOCKOUT_CYC ? UNLOCK_CYC : LOCKOUT_CYC;
    localparam int TW = $clog2(TMAX);
    localparam int IW = $clog2(CODE_LEN);
    typedef enum logic [1:0] {IDLE, ENTRY, UNLOCKED, LOCKOUT} state_t;
    state_t state_q, state_d;
    logic [CODE_LEN-1:0] code_q, code_d, shift_q, shift_d, shift_nx;
    logic [IW-1:0] idx_q, idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [FW-1:0] fail_q, fail_d;
    logic pulse_d;
    assign shift_nx = CODE_LEN'({shift_q, bit_in});
    assign fail_cnt = fail_q;
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        fail_d  = fail_q;
        pulse_d = 1'b0;
        case (state_q)
            IDLE, ENTRY: begin
                if (cancel) begin
                    state_d = IDLE;
                    shift_d = '0;
                    idx_d   = '0;
                end else if (state_q == IDLE && cfg_we) begin
                    code_d = cfg_code;
                end else if (bit_valid) begin
                    if (idx_q == IW'(CODE_LEN - 1)) begin
                        shift_d = '0;
                        idx_d   = '0;
                        if (shift_nx == code_q) begin
                            state_d = UNLOCKED;
                            fail_d  = '0;
                            timer_d = TW'(UNLOCK_CYC - 1);
                        end else begin
                            pulse_d = 1'b1;
                            fail_d  = fail_q == FW'(MAX_FAIL) ? fail_q : fail_q + FW'(1);
                            state_d = fail_q + FW'(1) == FW'(MAX_FAIL) ? LOCKOUT : IDLE;
                            timer_d = TW'(LOCKOUT_CYC - 1);
                        end
                    end else begin
                        shift_d = shift_nx;
                        idx_d   = idx_q + IW'(1);
                        state_d = ENTRY;
                    end
                end
            end
            UNLOCKED: begin
                state_d = relock || timer_q == '0 ? IDLE : UNLOCKED;
                timer_d = timer_q - TW'(1);
            end
            LOCKOUT: begin
                state_d = timer_q == '0 ? IDLE : LOCKOUT;
                fail_d  = timer_q == '0 ? '0 : fail_q;
                timer_d = timer_q - TW'(1);
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            code_q     <= RESET_CODE;
            shift_q    <= '0;
            idx_q      <= '0;
            timer_q    <= '0;
            fail_q     <= '0;
            unlocked   <= 1'b0;
            alarm      <= 1'b0;
            fail_pulse <= 1'b0;
            entry_busy <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            fail_q     <= fail_d;
            unlocked   <= state_d == UNLOCKED;
            alarm      <= state_d == LOCKOUT;
            fail_pulse <= pulse_d;
            entry_busy <= state_d == ENTRY;
        end
    end
endmodule

// File: tb/tb_lock_ctrl.sv
// tb_lock_ctrl: directed and randomized checks of lock_ctrl against a queue-based reference model
module tb_lock_ctrl;
    localparam int UNLOCK = 16;
    localparam int LOCKT = 64;
    localparam int MAXF = 3;
    logic clk = 1'b0;
    logic rst = 1'b1, bit_valid = 1'b0, bit_in = 1'b0, cancel = 1'b0, relock = 1'b0, cfg_we = 1'b0;
    logic [4:0] cfg_code = '0;
    logic unlocked, alarm, fail_pulse, entry_busy;
    logic [1:0] fail_cnt;
    int checks = 0, errors = 0;
    bit en = 1'b0;
    bit m_bits[$];
    int m_open = 0, m_lock = 0, m_fails = 0, m_pulse = 0, m_v;
    logic [4:0] m_code = 5'b01011;

    lock_ctrl dut (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in), .cancel(cancel),
        .relock(relock), .cfg_we(cfg_we), .cfg_code(cfg_code), .unlocked(unlocked),
        .alarm(alarm), .fail_pulse(fail_pulse), .fail_cnt(fail_cnt), .entry_busy(entry_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_bits.delete();
            m_open = 0;
            m_lock = 0;
            m_fails = 0;
            m_pulse = 0;
            m_code = 5'b01011;
        end else begin
            m_pulse = 0;
            if (m_lock > 0) begin
                m_lock--;
                if (m_lock == 0) m_fails = 0;
            end else if (m_open > 0) m_open = relock ? 0 : m_open - 1;
            else if (cancel) m_bits.delete();
            else if (m_bits.size() == 0 && cfg_we) m_code = cfg_code;
            else if (bit_valid) begin
                m_bits.push_back(bit_in);
                if (m_bits.size() == 5) begin
                    m_v = 0;
                    foreach (m_bits[i]) m_v = m_v * 2 + int'(m_bits[i]);
                    m_bits.delete();
                    if (m_v == int'(m_code)) begin
                        m_open = UNLOCK;
                        m_fails = 0;
                    end else begin
                        m_pulse = 1;
                        if (m_fails < MAXF) m_fails++;
                        if (m_fails == MAXF) m_lock = LOCKT;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (en) begin
            chk("unlocked", int'(unlocked), int'(m_open > 0));
            chk("alarm", int'(alarm), int'(m_lock > 0));
            chk("fail_pulse", int'(fail_pulse), m_pulse);
            chk("fail_cnt", int'(fail_cnt), m_fails);
            chk("entry_busy", int'(entry_busy), int'(m_bits.size() > 0));
        end
    end

    task automatic cyc(input logic v, input logic b, input logic c, input logic r,
                       input logic w, input logic [4:0] cc, input logic rs);
        bit_valid = v; bit_in = b; cancel = c; relock = r; cfg_we = w; cfg_code = cc; rst = rs;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [4:0] code);
        for (int i = 4; i >= 0; i--) cyc(1'b1, code[i], 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic hold(input string name, input int exp, input bit use_alarm, input bit feed);
        int n = 0;
        while ((use_alarm ? alarm : unlocked) && n < 300) begin
            n++;
            cyc(feed, 1'($urandom % 2), 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        end
        chk(name, n, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] pick;
        int sz;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        en = 1'b1;
        chk("rst_unlocked", int'(unlocked), 0);
        chk("rst_alarm", int'(alarm), 0);
        chk("rst_fail_cnt", int'(fail_cnt), 0);
        chk("rst_busy", int'(entry_busy), 0);
        send(5'b01011);
        chk("open_after_code", int'(unlocked), 1);
        hold("unlock_len", UNLOCK, 1'b0, 1'b0);
        chk("open_fail_cnt", int'(fail_cnt), 0);
        for (int k = 1; k <= 3; k++) begin
            send(5'b11111);
            chk("wrong_pulse", int'(fail_pulse), 1);
            chk("wrong_cnt", int'(fail_cnt), k);
        end
        chk("alarm_on", int'(alarm), 1);
        hold("lockout_len", LOCKT, 1'b1, 1'b1);
        chk("lockout_exit_cnt", int'(fail_cnt), 0);
        chk("lockout_exit_busy", int'(entry_busy), 0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'b10010, 1'b0);
        chk("cfg_beats_bit", int'(entry_busy), 0);
        send(5'b10010);
        chk("new_code_open", int'(unlocked), 1);
        hold("new_code_len", UNLOCK, 1'b0, 1'b0);
        send(5'b01011);
        chk("old_code_fails", int'(fail_pulse), 1);
        chk("old_code_cnt", int'(fail_cnt), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
        send(5'b11111);
        chk("pre_cancel_cnt", int'(fail_cnt), 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        chk("mid_entry_busy", int'(entry_busy), 1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        chk("cancel_busy", int'(entry_busy), 0);
        chk("cancel_cnt", int'(fail_cnt), 1);
        send(5'b01011);
        chk("after_cancel_open", int'(unlocked), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b10010, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        chk("relock", int'(unlocked), 0);
        send(5'b01011);
        chk("code_kept", int'(unlocked), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        for (int k = 0; k < 3; k++) send(5'b00000);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        chk("relock_ignored_lockout", int'(alarm), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
        chk("rst_lock_alarm", int'(alarm), 0);
        chk("rst_lock_cnt", int'(fail_cnt), 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
        chk("rst_entry_busy", int'(entry_busy), 0);
        send(5'b01011);
        chk("post_rst_open", int'(unlocked), 1);
        for (int t = 0; t < 4000; t++) begin
            sz = m_bits.size();
            pick = ($urandom % 2 == 0) ? 5'b10010 : 5'($urandom);
            cyc(1'($urandom % 2),
                ($urandom % 10 < 7 && sz < 5) ? m_code[4-sz] : 1'($urandom % 2),
                1'($urandom % 16 == 0), 1'($urandom % 16 == 0), 1'($urandom % 32 == 0),
                pick, 1'($urandom % 600 == 0));
        end
        en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lock_ctrl.md
# lock_ctrl

Sequencing controller for the electronic lock: accepts a serial code one bit per valid strobe, compares each complete CODE_LEN-bit entry against a programmable code, and drives the unlock, lockout and alarm outputs. It counts consecutive failed attempts and enforces timed unlock and lockout windows. It sits between the keypad/bit-entry front end and the door actuator and alarm logic.

## Interface
- CODE_LEN, 5: code length in bits (2..16).
- RESET_CODE, 5'b01011: code loaded at reset.
- MAX_FAIL, 3: consecutive failures that trigger lockout (1..15).
- UNLOCK_CYC, 16: cycles the lock stays open (≥2).
- LOCKOUT_CYC, 64: cycles of lockout (≥2).
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- bit_valid  in  1  qualifies bit_in for one cycle.
- bit_in  in  1  code bit; the first bit entered is compared against code MSB.
- cancel  in  1  abort a partial entry.
- relock  in  1  close the lock early while UNLOCKED.
- cfg_we  in  1  write cfg_code as the new code.
- cfg_code  in  CODE_LEN  new code value.
- unlocked  out  1  lock open.
- alarm  out  1  lockout active.
- fail_pulse  out  1  one-cycle pulse on each mismatched entry.
- fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive failure count.
- entry_busy  out  1  a partial entry is in progress.

## Operation
- States: IDLE, ENTRY, UNLOCKED, LOCKOUT. All outputs are registered.
- Reset values: state=IDLE, code=RESET_CODE, shift register=0, bit index=0, all outputs 0.
- IDLE with bit_valid: shift in the bit, set index=1, go to ENTRY. If CODE_LEN is reached on this bit, compare immediately.
- ENTRY with bit_valid: shift in the bit and increment the index. On the CODE_LEN-th bit, compare {shifted bits, bit_in} against code.
  - Match: go to UNLOCKED, clear fail_cnt, load the timer.
  - Mismatch: fail_pulse=1 for one cycle, fail_cnt+1. If the new count equals MAX_FAIL, go to LOCKOUT and load the timer. Otherwise go to IDLE.
  - In both cases the index and shift register clear.
- Whole-entry comparison only; there is no sliding-window match.
- cancel in IDLE or ENTRY: clear the index and shift register, go to IDLE, leave fail_cnt unchanged. When cancel and bit_valid occur in the same cycle, cancel wins and the bit is discarded.
- UNLOCKED: the timer decrements every cycle. At timer==0, or when relock=1, go to IDLE. bit_valid, cancel and cfg_we are ignored.
- LOCKOUT: alarm=1 and the timer decrements. At timer==0, go to IDLE and clear fail_cnt. All inputs except rst are ignored; relock does not exit LOCKOUT.
- cfg_we is accepted only in IDLE, and there it overrides bit_valid in the same cycle. It is ignored in ENTRY, UNLOCKED and LOCKOUT.
- entry_busy=1 exactly while state==ENTRY.
- fail_cnt saturates at MAX_FAIL and never wraps.
- rst in any state, including mid-entry, UNLOCKED or LOCKOUT, restores the reset values on the next edge, and the code reverts to RESET_CODE.

## Timing
- Final bit sampled at edge N: unlocked (or alarm, or fail_pulse) is high after edge N. Latency is 0 cycles past the sampling edge.
- unlocked stays high for exactly UNLOCK_CYC cycles (edges N+1..N+UNLOCK_CYC-1 keep it high; it falls at edge N+UNLOCK_CYC). The timer loads UNLOCK_CYC-1 at edge N.
- alarm stays high for exactly LOCKOUT_CYC cycles on the same rule. fail_cnt reads 0 after the exit edge.
- relock sampled at edge M while UNLOCKED: unlocked=0 after edge M.
- A new entry can start on the first cycle after returning to IDLE.
- A cfg_we sampled at edge K applies to entries compared after edge K.
- Bits may arrive back-to-back on consecutive cycles or with arbitrary gaps. There is no entry timeout.

## Test plan
- Reset, then bits 0,1,0,1,1 on consecutive cycles: unlocked rises after the 5th edge, holds 16 cycles, then falls. fail_cnt=0.
- Entry 1,1,1,1,1 three times: fail_pulse on each entry, fail_cnt goes 1,2,3. alarm rises after the 3rd entry, holds 64 cycles, and bit_valid is ignored meanwhile. fail_cnt=0 after exit.
- cfg_we with cfg_code=5'b10010 in IDLE, then entry 1,0,0,1,0: unlocked. The old code 01011 now fails with fail_cnt=1.
- Bits 0,1,0 then cancel asserted together with bit_valid: entry_busy falls, the bit is discarded. A full 01011 entered afterwards unlocks. fail_cnt is unchanged.
- relock asserted 4 cycles into UNLOCKED: unlocked=0 after that edge. cfg_we during UNLOCKED is ignored and the code stays 01011.
- rst asserted mid-LOCKOUT and mid-ENTRY: all outputs 0 after the edge, code=01011. A correct entry then unlocks.
